// File: rtl/debug_oci_pkg.sv
// Shared types and default widths for the OCI RAM sequencer/arbiter.
package debug_oci_pkg;

    localparam int OCI_ADDR_W = 8;
    localparam int OCI_DATA_W = 32;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_IDX_JTAG = 0;
    localparam int GNT_IDX_CPU  = 1;

    typedef enum logic [2:0] {
        IDLE,
        JTAG_ACC,
        CPU_ACC,
        RD_WAIT,
        RESP
    } oci_state_t;

    typedef enum logic {
        GNT_JTAG,
        GNT_CPU
    } oci_grant_t;

endpackage

// File: rtl/debug_oci_rr_arbiter.sv
// Two-requester arbiter (JTAG vs CPU); combinational, last_grant is held by the parent.
module debug_oci_rr_arbiter
    import debug_oci_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic       req_jtag,
    input  logic       req_cpu,
    input  oci_grant_t last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (req_jtag && req_cpu) begin
            // On a tie round-robin favours the side not served last; fixed priority favours JTAG.
            if ((RR != 0) && (last_grant == GNT_JTAG)) begin
                grant[GNT_IDX_CPU] = 1'b1;
            end else begin
                grant[GNT_IDX_JTAG] = 1'b1;
            end
        end else if (req_jtag) begin
            grant[GNT_IDX_JTAG] = 1'b1;
        end else if (req_cpu) begin
            grant[GNT_IDX_CPU] = 1'b1;
        end
    end

endmodule

// File: rtl/debug_ocimem_arbiter.sv
// Shares the single-port OCI RAM between the JTAG debug path and the CPU debug slave,
// sequencing address, read-wait and response phases and auto-incrementing the JTAG pointer.
module debug_ocimem_arbiter
    import debug_oci_pkg::*;
#(
    parameter int ADDR_W  = OCI_ADDR_W,
    parameter int DATA_W  = OCI_DATA_W,
    parameter int RR      = 1,
    parameter int RAM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jtag_addr_load,
    input  logic [ADDR_W-1:0]   jtag_addr,
    input  logic                jtag_go,
    input  logic                jtag_write,
    input  logic [DATA_W-1:0]   jtag_wdata,
    output logic                jtag_busy,
    output logic                jtag_overrun,
    output logic [DATA_W-1:0]   mon_dreg,
    output logic                mon_ready,
    input  logic                cpu_read,
    input  logic                cpu_write,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [DATA_W/8-1:0] cpu_byteenable,
    output logic                cpu_waitrequest,
    output logic [DATA_W-1:0]   cpu_readdata,
    output logic                cpu_readdatavalid,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata
);

    oci_state_t        state, next_state;
    oci_grant_t        last_grant;
    oci_grant_t        owner;
    logic [1:0]        grant;
    logic [1:0]        lat_cnt;
    logic [ADDR_W-1:0] ptr;
    logic              pending;
    logic              jt_write;
    logic [DATA_W-1:0] jt_wdata;
    logic              cpu_req;
    logic              lat_done;
    logic              in_jtag_access;
    logic              jtag_done;

    assign cpu_req  = cpu_read | cpu_write;
    assign lat_done = (lat_cnt == 2'(RAM_LAT - 1));

    assign in_jtag_access = (state == JTAG_ACC) ||
                            (((state == RD_WAIT) || (state == RESP)) && (owner == GNT_JTAG));
    assign jtag_busy      = pending | in_jtag_access;

    // A JTAG access completes at the end of a write address cycle or of its read response.
    assign jtag_done = ((state == JTAG_ACC) && jt_write) ||
                       ((state == RESP) && (owner == GNT_JTAG));

    assign cpu_waitrequest = reset || (state != CPU_ACC);

    debug_oci_rr_arbiter #(
        .RR(RR)
    ) u_arb (
        .req_jtag   (pending),
        .req_cpu    (cpu_req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant[GNT_IDX_JTAG]) begin
                    next_state = JTAG_ACC;
                end else if (grant[GNT_IDX_CPU]) begin
                    next_state = CPU_ACC;
                end
            end
            JTAG_ACC: next_state = jt_write ? IDLE : RD_WAIT;
            CPU_ACC:  next_state = cpu_read ? RD_WAIT : IDLE;
            RD_WAIT:  next_state = lat_done ? RESP : RD_WAIT;
            RESP:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Both read and write set means read, so a CPU write cycle requires cpu_read low.
    always_comb begin
        ram_addr       = ptr;
        ram_wdata      = jt_wdata;
        ram_byteenable = '1;
        ram_wren       = 1'b0;
        if (state == JTAG_ACC) begin
            ram_wren = jt_write && !reset;
        end else if (state == CPU_ACC) begin
            ram_addr       = cpu_addr;
            ram_wdata      = cpu_wdata;
            ram_byteenable = cpu_byteenable;
            ram_wren       = !cpu_read && !reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            last_grant        <= GNT_CPU;
            owner             <= GNT_CPU;
            lat_cnt           <= '0;
            mon_ready         <= 1'b0;
            cpu_readdatavalid <= 1'b0;
            mon_dreg          <= '0;
            cpu_readdata      <= '0;
        end else begin
            state             <= next_state;
            lat_cnt           <= (state == RD_WAIT) ? lat_cnt + 2'd1 : 2'd0;
            mon_ready         <= ((state == JTAG_ACC) && jt_write) ||
                                 ((state == RD_WAIT) && lat_done && (owner == GNT_JTAG));
            cpu_readdatavalid <= (state == RD_WAIT) && lat_done && (owner == GNT_CPU);
            if (state == JTAG_ACC) begin
                owner      <= GNT_JTAG;
                last_grant <= GNT_JTAG;
            end else if (state == CPU_ACC) begin
                owner      <= GNT_CPU;
                last_grant <= GNT_CPU;
            end
            if ((state == RD_WAIT) && lat_done) begin
                if (owner == GNT_CPU) begin
                    cpu_readdata <= ram_rdata;
                end else begin
                    mon_dreg <= ram_rdata;
                end
            end
        end
    end

    // Pointer load wins over the post-access increment if both land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= '0;
            pending      <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            if (jtag_done) begin
                pending <= 1'b0;
                ptr     <= ptr + ADDR_W'(1);
            end
            if (jtag_go && !jtag_busy) begin
                pending <= 1'b1;
            end
            if (jtag_addr_load) begin
                ptr          <= jtag_addr;
                jtag_overrun <= 1'b0;
            end
            if (jtag_go && jtag_busy) begin
                jtag_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (jtag_go && !jtag_busy) begin
            jt_write <= jtag_write;
            jt_wdata <= jtag_wdata;
        end
    end

endmodule
